// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access codes, FSM states,
// access-size encodings and the legal-code check.
package dmem_lsu_pkg;

    localparam logic [3:0] ACC_LB  = 4'b0100;
    localparam logic [3:0] ACC_LH  = 4'b0101;
    localparam logic [3:0] ACC_LW  = 4'b0110;
    localparam logic [3:0] ACC_LBU = 4'b0000;
    localparam logic [3:0] ACC_LHU = 4'b0001;
    localparam logic [3:0] ACC_SB  = 4'b1000;
    localparam logic [3:0] ACC_SH  = 4'b1001;
    localparam logic [3:0] ACC_SW  = 4'b1010;

    localparam int STORE_BIT = 3;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic is_legal_access(input logic [3:0] access);
        case (access)
            ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU,
            ACC_SB, ACC_SH, ACC_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// DMEM_LSU_MISALIGN_EN: flag misaligned halfword/word accesses; otherwise low bits are masked.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [3:0]  access,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [1:0] size;
    logic       sign_ld;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    assign size    = access[1:0];
    assign sign_ld = access[2];
    assign ld_byte = rdata[8*off +: 8];
    assign ld_half = rdata[16*off[1] +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SIZE_B: begin
                wstrb     = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ld & ld_byte[7]}}, ld_byte};
            end
            SIZE_H: begin
                wstrb     = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ld & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
        if (!access[STORE_BIT]) begin
            wstrb = 4'b0000;
        end
    end

`ifdef DMEM_LSU_MISALIGN_EN
    assign misaligned = ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one data-memory transaction per request over a req/gnt/rvalid port.
// Misalignment checking is enabled by DMEM_LSU_MISALIGN_EN (in dmem_lsu_align).
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_access,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic [3:0]        access_q, access_d;
    logic [1:0]        off_q, off_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        in_idle;
    logic        legal_req;
    logic [3:0]  al_access;
    logic [1:0]  al_off;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;

    // The aligner sees the incoming request while idle and the latched one afterwards.
    assign in_idle   = (state_q == ST_IDLE);
    assign al_access = in_idle ? req_access : access_q;
    assign al_off    = in_idle ? req_addr[1:0] : off_q;
    assign legal_req = is_legal_access(req_access) && (req_we == req_access[STORE_BIT])
                       && !al_misaligned;

    dmem_lsu_align u_align (
        .access     (al_access),
        .off        (al_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_rep  (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        access_d     = access_q;
        off_d        = off_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    access_d     = req_access;
                    off_d        = req_addr[1:0];
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (legal_req) begin
                        state_d     = ST_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr[ADDR_W-1:2];
                        mem_wstrb_d = al_wstrb;
                        mem_wdata_d = al_wdata;
                    end else begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0;
                    state_d     = access_q[STORE_BIT] ? ST_RESP : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    resp_rdata_d = al_rdata;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        resp_valid_d = (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            access_q     <= 4'b0000;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            access_q     <= access_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu; honours DMEM_LSU_MISALIGN_EN for the misaligned LW case.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_access;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_access (req_access),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the accepting edge.
    task automatic send(input logic [3:0] acc, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
        req_valid  = 1'b1;
        req_access = acc;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [3:0] acc, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp_data);
        send(acc, 1'b0, addr, 32'h0);
        check({tag, ".mem_req"}, {31'h0, mem_req}, 32'd1);
        check({tag, ".mem_addr"}, {2'b00, mem_addr}, addr >> 2);
        check({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        check({tag, ".wait_valid"}, {31'h0, resp_valid}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, exp_data);
        check({tag, ".resp_err"}, {31'h0, resp_err}, 32'd0);
        tick();
        check({tag, ".pulse_end"}, {31'h0, resp_valid}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [3:0] acc, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        send(acc, 1'b1, addr, wd);
        check({tag, ".mem_req"}, {31'h0, mem_req}, 32'd1);
        check({tag, ".mem_we"}, {31'h0, mem_we}, 32'd1);
        check({tag, ".mem_addr"}, {2'b00, mem_addr}, addr >> 2);
        check({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_strb});
        check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
        check({tag, ".resp_err"}, {31'h0, resp_err}, 32'd0);
        tick();
    endtask

    task automatic do_illegal(input string tag, input logic [3:0] acc, input logic we,
                              input logic [31:0] addr);
        send(acc, we, addr, 32'h1234_5678);
        check({tag, ".no_mem_req"}, {31'h0, mem_req}, 32'd0);
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'd1);
        check({tag, ".resp_err"}, {31'h0, resp_err}, 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
        tick();
        check({tag, ".ready_back"}, {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_access = 4'b0000;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) tick();
        check("rst.req_ready", {31'h0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst.mem_req", {31'h0, mem_req}, 32'd0);
        check("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        tick();

        do_load("lb_103",  4'b0100, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load("lhu_102", 4'b0001, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001);
        do_load("lh_102",  4'b0101, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lbu_100", 4'b0000, 32'h0000_0100, 32'h80FF_12B4, 32'h0000_00B4);
        do_load("lw_100",  4'b0110, 32'h0000_0100, 32'hCAFE_F00D, 32'hCAFE_F00D);

        do_store("sb_201", 4'b1000, 32'h0000_0201, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store("sh_202", 4'b1001, 32'h0000_0202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);

        do_illegal("acc_0111", 4'b0111, 1'b0, 32'h0000_0100);
        do_illegal("lw_we1",   4'b0110, 1'b1, 32'h0000_0100);
        do_illegal("sb_we0",   4'b1000, 1'b0, 32'h0000_0100);

        // Store with grant withheld for five cycles.
        send(4'b1010, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            check("sw_stall.mem_req", {31'h0, mem_req}, 32'd1);
            check("sw_stall.mem_addr", {2'b00, mem_addr}, 32'h0000_00C0);
            check("sw_stall.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("sw_stall.req_ready", {31'h0, req_ready}, 32'd0);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sw_stall.resp_valid", {31'h0, resp_valid}, 32'd1);
        tick();

        // Reset while waiting for read data; a late rvalid must be ignored.
        send(4'b0110, 1'b0, 32'h0000_0400, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_mid.req_ready", {31'h0, req_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        check("rst_mid.late_rvalid", {31'h0, resp_valid}, 32'd0);
        tick();
        check("rst_mid.late_rvalid2", {31'h0, resp_valid}, 32'd0);
        check("rst_mid.ready", {31'h0, req_ready}, 32'd1);

`ifdef DMEM_LSU_MISALIGN_EN
        do_illegal("lw_102_mis", 4'b0110, 1'b0, 32'h0000_0102);
`else
        do_load("lw_102_mask", 4'b0110, 32'h0000_0102, 32'h1357_9BDF, 32'h1357_9BDF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that consumes the decoder's memory-control outputs (4-bit access code, store enable) plus the ALU-computed address, and runs one data-memory transaction per request.
- Handles byte-lane steering, write strobes, and load sign/zero extension.
- Sits between the EX/MEM stage and a word-wide data memory with a request/grant/rvalid handshake.
- Returns write-back data to the rf write-back mux (memory-data input).

Parameters:
- ADDR_W, 32, byte address width on the core side; mem_addr is ADDR_W-2 bits (word address).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
- req_access  in  4  access code: 0100 LB, 0101 LH, 0110 LW, 0000 LBU, 0001 LHU, 1000 SB, 1001 SH, 1010 SW.
- req_we  in  1  store enable from decoder; must equal req_access[3].
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data (rs2 value).
- resp_valid  out  1  one-cycle pulse; the core must accept it.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal code, we/code mismatch, or misalignment (see feature).
- mem_req  out  1  held high until mem_gnt.
- mem_gnt  in  1  memory accepted the request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2].
- mem_wstrb  out  4  byte write strobes; 0 for reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid; earliest one cycle after gnt.
- mem_rdata  in  32  read word.

Behaviour:
- States: IDLE, ISSUE, WAIT_R, RESP.
- Reset:
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Latched request registers cleared.
- IDLE:
  - req_ready=1.
  - On transfer, latch access, addr, wdata.
  - Legal request → ISSUE. Illegal request → RESP with err=1 and no memory activity.
  - Illegal means: a code outside the list, or req_we != req_access[3].
- ISSUE:
  - mem_req=1; mem_we/addr/wstrb/wdata driven from latched values and held stable until mem_gnt.
  - On gnt: store → RESP; load → WAIT_R.
  - mem_rvalid is ignored in ISSUE.
- WAIT_R:
  - Wait unbounded for mem_rvalid.
  - On rvalid, register the extracted data → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata/resp_err registered → IDLE.
  - req_ready=0, so back-to-back requests have a minimum 1-cycle bubble.
- Latency (load, gnt in first ISSUE cycle, rvalid one cycle later): accept at cycle T, resp_valid at T+3. Store: resp_valid at T+2.
- Lane steering, with off=addr[1:0]:
  - SB: wdata={4{b}}, wstrb=0001<<off.
  - SH: wdata={2{h}}, wstrb=0011<<{off[1],0}.
  - SW: wdata=word, wstrb=1111.
- Load extraction:
  - byte = rdata[8*off+:8].
  - half = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the whole word.
- Reset mid-operation:
  - Abandons the transaction: IDLE next cycle, mem_req dropped.
  - A late mem_rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: DMEM_LSU_MISALIGN_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Misaligned request → RESP with err=1, no mem_req, rdata=0.
- Undefined:
  - Offending low bits are masked: halfword uses off[1]; word ignores off.
  - The access proceeds normally with err=0.

Decomposition:
- Package dmem_lsu_pkg:
  - localparams for the eight access codes and the store bit index (3).
  - State encoding (2-bit: IDLE=0, ISSUE=1, WAIT_R=2, RESP=3).
  - Helper constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10, taken from access[1:0].
- Sub-module dmem_lsu_align (combinational):
  - Inputs: access, off, wdata, rdata.
  - Outputs: wstrb, wdata_rep, rdata_ext, misaligned.
  - The FSM stays in dmem_lsu.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234, gnt immediate, rvalid next cycle → resp_rdata=0xFFFF_FF80, resp_valid at T+3, err=0.
- LHU at addr 0x102, rdata=0x8001_0000 → resp_rdata=0x0000_8001; LH at the same address → 0xFFFF_8001.
- SB addr 0x201, wdata=0x0000_00AB → mem_wdata=0xABAB_ABAB, mem_wstrb=0010, mem_addr=0x80, resp_valid at T+2 with rdata=0. SH addr 0x202 → wstrb=1100.
- Request with access=0111 (or req_we=1 with access=0110) → no mem_req, resp_valid one cycle after accept, err=1.
- SW with mem_gnt held low 5 cycles → mem_req, mem_addr and mem_wdata stable all 5 cycles, and req_ready=0 throughout. Then rst asserted in WAIT_R of a following LW → IDLE next cycle; a later mem_rvalid produces no resp_valid.
- LW at addr 0x102:
  - With DMEM_LSU_MISALIGN_EN: err=1, no mem_req.
  - Without it: mem_addr=0x40, resp_rdata=the full word, err=0.
